sort_stream_ctrl: RTL
=====================

Name: sort_stream_ctrl

Overview:
- Sequencer wrapped around the parallel bitonic sort core (`sort`).
- Accepts a serial element stream on a valid/ready interface and packs up to 2**LOG_INPUT elements into the sorter's wide input vector.
- Launches one sort, waits for the result, then drains the sorted vector serially on a second valid/ready interface.
- Short frames are padded so that pad entries sort to the tail and are never emitted.

Parameters:
- LOG_INPUT, 3, log2 of sorter lanes; N = 2**LOG_INPUT.
- DATA_WIDTH, 4, bits per element.
- ASCENDING, 0, must match the sorter instance; selects the pad value.
- TIMEOUT, 255, maximum cycles in WAIT before abort; 8-bit-or-wider counter sized by $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts element.
- in_data  in  DATA_WIDTH  input element.
- in_last  in  1  final element of frame.
- out_valid  out  1  sorted element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  sorted element.
- out_last  out  1  final real element of frame.
- sort_x  out  DATA_WIDTH*N  packed vector to sorter; lane i = bits [DATA_WIDTH*i +: DATA_WIDTH].
- sort_x_valid  out  1  launch strobe to sorter.
- sort_y  in  DATA_WIDTH*N  sorter result.
- sort_y_valid  in  1  sorter result valid.
- busy  out  1  high in any state except LOAD with count 0.
- timeout_err  out  1  sticky, set on WAIT timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, count=0.
  - in_ready=0 while rst low; 1 from the first cycle after release.
  - out_valid=0, out_last=0, out_data=0, sort_x=0, sort_x_valid=0, busy=0, timeout_err=0.
  - Reset mid-operation abandons the frame; any late sort_y_valid is ignored because state is LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: write in_data to lane count, count+=1.
  - Go to LAUNCH when count reaches N, or when in_last is accepted (count+1 ≤ N).
  - Real count R is latched as 1..N.
  - in_last on the Nth element is allowed. An Nth element without in_last closes the frame anyway; the next element starts a new frame.
- LAUNCH (1 cycle):
  - Lanes ≥ R are filled with PAD: all-ones when ASCENDING=1, all-zeros when ASCENDING=0, so pads sort to the tail.
  - sort_x_valid=1 for exactly this cycle; sort_x is then held stable until leaving WAIT.
  - Go to WAIT. in_ready=0.
- WAIT:
  - Cycle counter runs.
  - On sort_y_valid=1: capture sort_y into the result register, idx=0, go to DRAIN.
  - If the counter reaches TIMEOUT first: set timeout_err, go to LOAD, count=0. Nothing is emitted.
  - sort_y_valid outside WAIT is ignored.
- DRAIN:
  - out_valid=1, out_data=result lane idx, out_last=(idx==R-1).
  - Lane 0 is first in sorted order.
  - On out_valid&out_ready: idx+=1. After the transfer with out_last, go to LOAD with count=0.
  - out_data/out_last are stable while out_valid=1 and out_ready=0.
  - in_ready=0 throughout; there is no input/output overlap.
- Latency: last input accept → sort_x_valid on the next cycle. sort_y_valid → out_valid on the next cycle.
- Elements equal to PAD are legal; only R elements are emitted, and equal values are indistinguishable.
- timeout_err clears only on reset.

Test Plan:
1. Full frame, N=8, W=4, ASCENDING=0. Stream 5,1,2,3,6,7,2,1 (in_last on 8th); model the sorter with 6-cycle latency → sort_x_valid pulses once; out_data sequence 7,6,5,3,2,2,1,1; out_last only on the 8th.
2. Short frame R=3, ASCENDING=0. Stream 4,9,2 with in_last → sort_x lanes 3..7 = 0; output 9,4,2 with out_last on 2; no 4th output.
3. Short frame, ASCENDING=1. Stream 15,0 → pads = 4'hF; output 0,15; exactly 2 transfers.
4. Backpressure. out_ready toggles 1,0,0,1,… during DRAIN → no element lost or duplicated; out_data held while stalled; in_ready=0 throughout DRAIN.
5. Timeout, TIMEOUT=10. No sort_y_valid → timeout_err=1 after 10 WAIT cycles; state returns to LOAD; a subsequent frame sorts correctly with timeout_err still 1.
6. Reset mid-DRAIN after 3 outputs. Assert rst low → out_valid=0 immediately. A stale sort_y_valid after release produces no output; the next frame of 1 element (value 8) outputs 8 with out_last=1.

Source files
------------

// File: rtl/sort_stream_ctrl.sv
// Stream-to-vector sequencer around a parallel bitonic sorter: packs one frame
// into the sorter input, launches a single sort, then drains the sorted lanes serially.
module sort_stream_ctrl #(
  parameter int LOG_INPUT  = 3,
  parameter int DATA_WIDTH = 4,
  parameter bit ASCENDING  = 1'b0,
  parameter int TIMEOUT    = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // valid/ready: a transfer happens on a rising edge where valid && ready; the
  // source holds data/last stable from raising valid until that transfer.
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] sort_x,
  output logic                                 sort_x_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] sort_y,
  input  logic                                 sort_y_valid,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic [1:0]                           dbg_state
);
  localparam int N  = 2 ** LOG_INPUT;
  localparam int VW = DATA_WIDTH * N;
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [DATA_WIDTH-1:0] PAD      = {DATA_WIDTH{ASCENDING}};
  localparam logic [LOG_INPUT:0]    ONE      = {{LOG_INPUT{1'b0}}, 1'b1};
  localparam logic [TW-1:0]         TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic [LOG_INPUT-1:0] count_q, count_d;
  logic [LOG_INPUT-1:0] idx_q, idx_d;
  logic [LOG_INPUT:0]   rcnt_q, rcnt_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [VW-1:0]        sort_x_q, sort_x_d;
  logic [VW-1:0]        result_q, result_d;
  logic                 timeout_q, timeout_d;
  logic                 frame_close;
  logic                 drain_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      run_q     <= 1'b0;
      count_q   <= '0;
      idx_q     <= '0;
      rcnt_q    <= '0;
      tmr_q     <= '0;
      sort_x_q  <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      rcnt_q    <= rcnt_d;
      tmr_q     <= tmr_d;
      sort_x_q  <= sort_x_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    count_d      = count_q;
    idx_d        = idx_q;
    rcnt_d       = rcnt_q;
    tmr_d        = tmr_q;
    sort_x_d     = sort_x_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    in_ready     = run_q && (state_q == S_LOAD);
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    sort_x_valid = 1'b0;
    frame_close  = in_last || (&count_q);
    drain_last   = ({1'b0, idx_q} == (rcnt_q - ONE));

    unique case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          // Padding is written together with the closing element so sort_x is
          // already complete during the launch cycle.
          for (int i = 0; i < N; i++) begin
            if (LOG_INPUT'(i) == count_q) begin
              sort_x_d[DATA_WIDTH*i +: DATA_WIDTH] = in_data;
            end else if (frame_close && (LOG_INPUT'(i) > count_q)) begin
              sort_x_d[DATA_WIDTH*i +: DATA_WIDTH] = PAD;
            end
          end
          if (frame_close) begin
            state_d = S_LAUNCH;
            rcnt_d  = {1'b0, count_q} + ONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        sort_x_valid = 1'b1;
        tmr_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (sort_y_valid) begin
          result_d = sort_y;
          idx_d    = '0;
          state_d  = S_DRAIN;
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          count_d   = '0;
          state_d   = S_LOAD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = result_q[DATA_WIDTH*idx_q +: DATA_WIDTH];
        out_last  = drain_last;
        if (out_ready) begin
          if (drain_last) begin
            count_d = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign sort_x      = sort_x_q;
  assign busy        = !((state_q == S_LOAD) && (count_q == '0));
  assign timeout_err = timeout_q;
  assign dbg_state   = state_q;

endmodule
